// File: rtl/mem_lsu_ctrl.sv
// Purpose: sequences byte/half/word loads and stores into single-byte memory cycles; LSU_MISALIGNED_EN accepts misaligned half/word.
// Latency: rsp_valid N+1 cycles after accept (N = 1/2/4 bytes), 1 cycle for rejected requests.
// Backpressure: req_ready high only while idle; the response pulse cannot be stalled.
module mem_lsu_ctrl #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [AWIDTH-1:0] mem_addr,
    inout  wire  [DWIDTH-1:0] mem_data
);

    if (DWIDTH != 8) begin : g_bad_dwidth
        $error("mem_lsu_ctrl: DWIDTH must be 8");
    end
    if (AWIDTH < 2) begin : g_bad_awidth
        $error("mem_lsu_ctrl: AWIDTH must be >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic                err_q, err_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [1:0]          k_q, k_d;
    logic [31:0]         asm_q, asm_d;
    logic                mem_wr_q, mem_wr_d;
    logic                mem_rd_q, mem_rd_d;
    logic [AWIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DWIDTH-1:0]   mem_wdat_q, mem_wdat_d;

    logic                req_illegal;
    logic                req_err;
    logic [1:0]          last_k;
    logic [1:0]          k_next;

    assign req_illegal = (req_size == 2'b11);

`ifdef LSU_MISALIGNED_EN
    assign req_err = req_illegal;
`else
    logic req_misal;
    assign req_misal = ((req_size == 2'b01) && req_addr[0]) ||
                       ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    assign req_err   = req_illegal | req_misal;
`endif

    // Index of the final byte cycle for the latched access size.
    always_comb begin
        last_k = 2'd0;
        case (size_q)
            2'b01:   last_k = 2'd1;
            2'b10:   last_k = 2'd3;
            default: last_k = 2'd0;
        endcase
    end

    assign k_next = k_q + 2'd1;

    // Memory strobes, address and write byte are registered one cycle ahead so the pins never glitch.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        size_d     = size_q;
        uns_d      = uns_q;
        err_d      = err_q;
        wdata_d    = wdata_q;
        k_d        = k_q;
        asm_d      = asm_q;
        mem_wr_d   = 1'b0;
        mem_rd_d   = 1'b0;
        mem_addr_d = '0;
        mem_wdat_d = '0;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    err_d   = req_err;
                    k_d     = 2'd0;
                    asm_d   = '0;
                    if (req_err) begin
                        state_d = S_RESP;
                    end else begin
                        state_d    = S_ACCESS;
                        mem_wr_d   = req_we;
                        mem_rd_d   = ~req_we;
                        mem_addr_d = req_addr;
                        mem_wdat_d = req_we ? req_wdata[7:0] : '0;
                    end
                end
            end
            S_ACCESS: begin
                if (!we_q) begin
                    asm_d[{k_q, 3'b000} +: 8] = mem_data[7:0];
                end
                if (k_q == last_k) begin
                    state_d = S_RESP;
                end else begin
                    k_d        = k_next;
                    mem_wr_d   = we_q;
                    mem_rd_d   = ~we_q;
                    mem_addr_d = mem_addr_q + AWIDTH'(1);
                    mem_wdat_d = we_q ? wdata_q[{k_next, 3'b000} +: 8] : '0;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            err_q      <= 1'b0;
            wdata_q    <= '0;
            k_q        <= 2'd0;
            asm_q      <= '0;
            mem_wr_q   <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_wdat_q <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            err_q      <= err_d;
            wdata_q    <= wdata_d;
            k_q        <= k_d;
            asm_q      <= asm_d;
            mem_wr_q   <= mem_wr_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            mem_wdat_q <= mem_wdat_d;
        end
    end

    // Load result is extended only while the response is shown; stores and errors read as zero.
    always_comb begin
        rsp_rdata = '0;
        if ((state_q == S_RESP) && !we_q && !err_q) begin
            case (size_q)
                2'b00:   rsp_rdata = {{24{asm_q[7] & ~uns_q}}, asm_q[7:0]};
                2'b01:   rsp_rdata = {{16{asm_q[15] & ~uns_q}}, asm_q[15:0]};
                default: rsp_rdata = asm_q;
            endcase
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_err   = (state_q == S_RESP) && err_q;
    assign mem_wr    = mem_wr_q;
    assign mem_rd    = mem_rd_q;
    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_wr_q ? mem_wdat_q : {DWIDTH{1'bz}};

endmodule
